// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, requester
// count and the byte-select helper.
package uart_pkg;

  localparam int unsigned UART_REQ_NUM    = 2;
  localparam int unsigned UART_BYTE_IDX_W = 2;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSend     = 3'd1,
    StWaitDone = 3'd2,
    StFinish   = 3'd3,
    StAbort    = 3'd4
  } uart_state_e;

  // Byte idx of a little-endian 32-bit word.
  function automatic logic [7:0] uart_byte(input logic [31:0]                data,
                                           input logic [UART_BYTE_IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_rr_arbiter.sv
// Two-way round-robin arbiter. Purely combinational; the owner of last_id
// decides when the pointer moves.
module uart_tx_rr_arbiter
  import uart_pkg::*;
(
  input  logic [UART_REQ_NUM-1:0] valid,
  input  logic                    last_id,
  output logic [UART_REQ_NUM-1:0] grant,
  output logic                    grant_id
);

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grant    = '0;
    grant[0] = valid[0] & (~valid[1] | last_id);
    grant[1] = valid[1] & (~valid[0] | ~last_id);
    grant_id = grant[1];
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the UART transmitter between two requesters, sending a 1-4 byte word
// per request one byte at a time with a per-byte completion timeout.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  input  logic [31:0] i_req0_data,
  input  logic [1:0]  i_req0_len,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [31:0] i_req1_data,
  input  logic [1:0]  i_req1_len,
  output logic        o_req1_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_send,
  input  logic        i_tx_done,
  output logic [1:0]  o_req_done,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_grant_id
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  uart_state_e                state_q, state_d;
  logic [31:0]                data_q, data_d;
  logic [1:0]                 len_q, len_d;
  logic                       id_q, id_d;
  logic [UART_BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       ptr_q, ptr_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_send_q, tx_send_d;
  logic [1:0]                 req_done_q, req_done_d;
  logic                       err_q, err_d;
  logic                       busy_q, busy_d;

  logic [UART_REQ_NUM-1:0] grant;
  logic                    grant_id;

  uart_tx_rr_arbiter u_arb (
    .valid    ({i_req1_valid, i_req0_valid}),
    .last_id  (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign o_req0_ready = (state_q == StIdle) & grant[0];
  assign o_req1_ready = (state_q == StIdle) & grant[1];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    id_d    = id_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;

    case (state_q)
      StIdle: begin
        if (|grant) begin
          data_d  = grant_id ? i_req1_data : i_req0_data;
          len_d   = grant_id ? i_req1_len : i_req0_len;
          id_d    = grant_id;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        cnt_d   = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        cnt_d = cnt_q + CntW'(1);
        // A done arriving on the final allowed cycle still counts as success.
        if (i_tx_done) begin
          if (idx_q == len_q) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + UART_BYTE_IDX_W'(1);
            state_d = StSend;
          end
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StAbort;
        end
      end
      StFinish: begin
        ptr_d   = id_q;
        state_d = StIdle;
      end
      StAbort: begin
        ptr_d   = id_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_send_d  = (state_d == StSend);
    req_done_d = '0;
    err_d      = (state_d == StAbort);
    busy_d     = (state_d != StIdle);
    if (state_d == StSend) begin
      tx_data_d = uart_byte(data_d, idx_d);
    end
    if (state_d == StFinish) begin
      req_done_d[id_d] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      data_q     <= '0;
      len_q      <= '0;
      id_q       <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      ptr_q      <= 1'b1;
      tx_data_q  <= 8'h00;
      tx_send_q  <= 1'b0;
      req_done_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      len_q      <= len_d;
      id_q       <= id_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      tx_send_q  <= tx_send_d;
      req_done_q <= req_done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_send  = tx_send_q;
  assign o_req_done = req_done_q;
  assign o_err      = err_q;
  assign o_busy     = busy_q;
  assign o_grant_id = id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a negedge monitor logs sends, grants,
// completions and errors while a simple responder models the TX controller.
module tb_uart_tx_scheduler;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req0_valid = 1'b0;
  logic [31:0] i_req0_data = '0;
  logic [1:0]  i_req0_len = '0;
  logic        o_req0_ready;
  logic        i_req1_valid = 1'b0;
  logic [31:0] i_req1_data = '0;
  logic [1:0]  i_req1_len = '0;
  logic        o_req1_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_send;
  logic        i_tx_done = 1'b0;
  logic [1:0]  o_req_done;
  logic        o_err;
  logic        o_busy;
  logic        o_grant_id;

  uart_tx_scheduler #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (i_req0_valid),
    .i_req0_data  (i_req0_data),
    .i_req0_len   (i_req0_len),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_data  (i_req1_data),
    .i_req1_len   (i_req1_len),
    .o_req1_ready (o_req1_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_send    (o_tx_send),
    .i_tx_done    (i_tx_done),
    .o_req_done   (o_req_done),
    .o_err        (o_err),
    .o_busy       (o_busy),
    .o_grant_id   (o_grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] sent_q[$];
  int         acc_q[$];
  int         send_cnt, done_cnt, err_cnt;
  logic [1:0] last_done;
  int         send_cyc, err_cyc, done_cyc, done_set_cyc;
  int         rem0, rem1;
  bit         pend0, pend1, scramble0;
  bit         resp_en = 1'b1;
  bit         resp_pulse, spur_send;
  int         cd;
  int         resp_delay = 5;

  // Monitor, requester drop-off and TX controller model.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (pend0) begin
        pend0 = 1'b0;
        if (rem0 > 0) rem0--;
        if (rem0 == 0) i_req0_valid = 1'b0;
        if (scramble0) i_req0_data = ~i_req0_data;
      end
      if (pend1) begin
        pend1 = 1'b0;
        if (rem1 > 0) rem1--;
        if (rem1 == 0) i_req1_valid = 1'b0;
      end
      if (i_req0_valid && o_req0_ready) begin acc_q.push_back(0); pend0 = 1'b1; end
      if (i_req1_valid && o_req1_ready) begin acc_q.push_back(1); pend1 = 1'b1; end
      if (o_tx_send) begin sent_q.push_back(o_tx_data); send_cnt++; send_cyc = cyc; end
      if (o_req_done != 2'b00) begin done_cnt++; last_done = o_req_done; done_cyc = cyc; end
      if (o_err) begin err_cnt++; err_cyc = cyc; end
      if (resp_pulse) begin i_tx_done = 1'b0; resp_pulse = 1'b0; end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin i_tx_done = 1'b1; resp_pulse = 1'b1; done_set_cyc = cyc; end
      end
      if (o_tx_send) begin
        if (resp_en) cd = resp_delay;
        if (spur_send) begin i_tx_done = 1'b1; resp_pulse = 1'b1; end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    sent_q.delete();
    acc_q.delete();
    send_cnt = 0; done_cnt = 0; err_cnt = 0; last_done = 2'b00;
    send_cyc = 0; err_cyc = 0; done_cyc = 0; done_set_cyc = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_tx_done = 1'b0;
    cd = 0; resp_pulse = 1'b0; rem0 = 0; rem1 = 0; pend0 = 1'b0; pend1 = 1'b0;
    scramble0 = 1'b0; spur_send = 1'b0; resp_en = 1'b1;
    clear_logs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_events(input int n, input int budget, input string name);
    int i;
    for (i = 0; i < budget && (done_cnt + err_cnt) < n; i++) begin
      @(negedge clk);
      #2;
    end
    if ((done_cnt + err_cnt) < n) begin
      tests_run++; tests_failed++;
      $display("FAIL %s timeout: got %0d word events, required %0d", name, done_cnt + err_cnt, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    tests_run++;
    if (o_tx_data !== 8'h00) begin tests_failed++; $display("FAIL rst_tx_data: got %h required 00", o_tx_data); end
    tests_run++;
    if ({o_tx_send, o_err, o_busy, o_grant_id} !== 4'b0000) begin
      tests_failed++; $display("FAIL rst_ctrl: got %b required 0000", {o_tx_send, o_err, o_busy, o_grant_id});
    end
    tests_run++;
    if (o_req_done !== 2'b00) begin tests_failed++; $display("FAIL rst_req_done: got %b required 00", o_req_done); end
  endtask

  task automatic test_multi_byte();
    logic [7:0] exp_b[4];
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    do_reset();
    i_req0_data = 32'hA1B2C3D4; i_req0_len = 2'd3; rem0 = 1; scramble0 = 1'b1;
    i_req0_valid = 1'b1;
    wait_events(1, 200, "multi_byte");
    tests_run++;
    if (send_cnt !== 4) begin tests_failed++; $display("FAIL mb_sends: got %0d required 4", send_cnt); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= sent_q.size()) begin
        tests_failed++; $display("FAIL mb_byte%0d: missing, required %h", i, exp_b[i]);
      end else if (sent_q[i] !== exp_b[i]) begin
        tests_failed++; $display("FAIL mb_byte%0d: got %h required %h", i, sent_q[i], exp_b[i]);
      end
    end
    tests_run++;
    if (done_cnt !== 1 || last_done !== 2'b01) begin
      tests_failed++; $display("FAIL mb_done: got %0d pulses value %b required 1 pulse 01", done_cnt, last_done);
    end
    tests_run++;
    if (done_cyc !== done_set_cyc + 1) begin
      tests_failed++; $display("FAIL mb_done_timing: got cycle %0d required %0d", done_cyc, done_set_cyc + 1);
    end
    scramble0 = 1'b0;
  endtask

  task automatic test_tie();
    do_reset();
    i_req0_data = 32'h11; i_req1_data = 32'h22; i_req0_len = 2'd0; i_req1_len = 2'd0;
    rem0 = 1; rem1 = 1;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    wait_events(2, 200, "tie1");
    tests_run++;
    if (acc_q.size() != 2 || acc_q[0] != 0 || acc_q[1] != 1) begin
      tests_failed++; $display("FAIL tie_order: got %p required 0,1", acc_q);
    end
    tests_run++;
    if (sent_q.size() != 2 || sent_q[0] !== 8'h11 || sent_q[1] !== 8'h22) begin
      tests_failed++; $display("FAIL tie_bytes: got %p required 11,22", sent_q);
    end
    clear_logs();
    @(negedge clk);
    rem0 = 1; rem1 = 1;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    wait_events(2, 200, "tie2");
    tests_run++;
    if (acc_q.size() != 2 || acc_q[0] != 0 || acc_q[1] != 1) begin
      tests_failed++; $display("FAIL tie_again: got %p required 0,1", acc_q);
    end
  endtask

  task automatic test_back_to_back();
    int exp_a[5];
    logic [7:0] exp_b[5];
    exp_a = '{0, 1, 0, 1, 1};
    exp_b = '{8'h33, 8'h44, 8'h33, 8'h44, 8'h44};
    do_reset();
    i_req0_data = 32'h33; i_req1_data = 32'h44; i_req0_len = 2'd0; i_req1_len = 2'd0;
    rem0 = 2; rem1 = 3;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    wait_events(5, 400, "fair");
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= acc_q.size() || i >= sent_q.size()) begin
        tests_failed++; $display("FAIL fair_word%0d: missing, required id %0d", i, exp_a[i]);
      end else if (acc_q[i] != exp_a[i] || sent_q[i] !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL fair_word%0d: got id %0d byte %h required id %0d byte %h",
                 i, acc_q[i], sent_q[i], exp_a[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    resp_en = 1'b0;
    i_req0_data = 32'h0000BEEF; i_req0_len = 2'd1; rem0 = 1;
    i_req0_valid = 1'b1;
    for (int i = 0; i < 100 && err_cnt == 0 && done_cnt == 0; i++) begin
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    #2;
    tests_run++;
    if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL to_busy: got %b required 0", o_busy); end
    tests_run++;
    if (err_cnt != 1) begin tests_failed++; $display("FAIL to_err_count: got %0d required 1", err_cnt); end
    tests_run++;
    if (err_cyc - send_cyc != TO + 1) begin
      tests_failed++; $display("FAIL to_latency: got %0d required %0d", err_cyc - send_cyc, TO + 1);
    end
    tests_run++;
    if (done_cnt != 0 || send_cnt != 1) begin
      tests_failed++; $display("FAIL to_abort: got %0d done %0d sends required 0 done 1 send", done_cnt, send_cnt);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_spurious();
    do_reset();
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    tests_run++;
    if (o_busy !== 1'b0 || send_cnt != 0 || done_cnt != 0) begin
      tests_failed++; $display("FAIL spur_idle: got busy %b sends %0d done %0d required 0 0 0", o_busy, send_cnt, done_cnt);
    end
    spur_send = 1'b1;
    i_req0_data = 32'h00005566; i_req0_len = 2'd1; rem0 = 1;
    i_req0_valid = 1'b1;
    wait_events(1, 200, "spur_send");
    tests_run++;
    if (sent_q.size() != 2 || sent_q[0] !== 8'h66 || sent_q[1] !== 8'h55) begin
      tests_failed++; $display("FAIL spur_bytes: got %p required 66,55", sent_q);
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != done_set_cyc + 1) begin
      tests_failed++; $display("FAIL spur_done: got %0d at cycle %0d required 1 at %0d", done_cnt, done_cyc, done_set_cyc + 1);
    end
    spur_send = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_req0_data = 32'h01020304; i_req0_len = 2'd3; rem0 = 1;
    i_req0_valid = 1'b1;
    for (int i = 0; i < 100 && send_cnt < 2; i++) begin
      @(negedge clk);
      #2;
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_tx_data, o_tx_send, o_req_done, o_err, o_busy, o_grant_id} !== 14'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got data %h send %b done %b err %b busy %b gid %b required all 0",
               o_tx_data, o_tx_send, o_req_done, o_err, o_busy, o_grant_id);
    end
    do_reset();
    i_req0_data = 32'h77; i_req0_len = 2'd0; rem0 = 1;
    i_req0_valid = 1'b1;
    wait_events(1, 200, "post_reset");
    tests_run++;
    if (sent_q.size() != 1 || sent_q[0] !== 8'h77 || last_done !== 2'b01) begin
      tests_failed++; $display("FAIL post_reset_word: got %p done %b required 77 done 01", sent_q, last_done);
    end
  endtask

  initial begin
    test_reset();
    test_multi_byte();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Two-requester scheduler that owns the UART transmitter and shares it between the CPU store port (requester 0) and the debug/trace port (requester 1). It accepts a 1–4 byte word per request, arbitrates round-robin, and sequences each byte into the UART TX controller: one send pulse per byte, then a wait for frame completion. It sits between the memory-mapped UART register block and the UART TX controller/datapath.

## Interface
- TIMEOUT_CYCLES, 2_000_000: maximum cycles to wait for `i_tx_done` after a send pulse; must be ≥ 1.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req0_valid  in  1  requester 0 has a word.
- i_req0_data  in  32  requester 0 payload; byte 0 = [7:0].
- i_req0_len  in  2  requester 0 byte count minus one (0 → 1 byte, 3 → 4 bytes).
- o_req0_ready  out  1  requester 0 accepted this cycle when `valid & ready`.
- i_req1_valid, i_req1_data, i_req1_len, o_req1_ready: same as requester 0.
- o_tx_data  out  8  byte presented to the UART TX data register.
- o_tx_send  out  1  one-cycle start pulse to the UART TX controller.
- i_tx_done  in  1  one-cycle pulse from the UART TX controller when the frame, including stop bit and inter-frame delay, is complete.
- o_req_done  out  2  one-cycle pulse on bit N when requester N's word has fully transmitted.
- o_err  out  1  one-cycle pulse when a byte times out; the word is aborted.
- o_busy  out  1  high in every state except IDLE.
- o_grant_id  out  1  requester currently owning the transmitter; valid while `o_busy`.

## Operation
- States: IDLE, SEND, WAIT_DONE, FINISH, ABORT.
- **IDLE**
  - Arbiter picks among valid requesters.
  - If both are valid, the requester not granted last wins. After reset, the last-grant pointer is 1, so requester 0 wins the first tie.
  - Only the winner's ready is high. Ready is combinational from valids and the pointer.
  - On accept: capture data, len and id; clear the byte index; go to SEND.
- **SEND**
  - `o_tx_send` = 1 for exactly this cycle.
  - `o_tx_data` = captured byte[idx].
  - Load the timeout counter with 0.
  - Go to WAIT_DONE.
- **WAIT_DONE**
  - Counter increments every cycle.
  - On `i_tx_done`: if idx == len, go to FINISH; otherwise idx+1 and go to SEND.
  - If the counter reaches TIMEOUT_CYCLES without `i_tx_done`, go to ABORT.
- **FINISH**
  - Pulse `o_req_done[id]`.
  - Last-grant pointer := id.
  - Go to IDLE.
- **ABORT**
  - Pulse `o_err`. No `o_req_done` pulse.
  - Last-grant pointer := id.
  - Go to IDLE.
- `o_tx_data` holds its value from SEND through WAIT_DONE. It changes only on entry to SEND.
- `i_tx_done` is ignored outside WAIT_DONE, including a pulse coincident with SEND.
- Requester data or valid changing after accept has no effect on the word in flight.
- Unused encodings go to IDLE with all pulses low.
- **Reset (async, any state):**
  - State = IDLE, idx = 0, counter = 0, pointer = 1.
  - `o_tx_data` = 8'h00.
  - `o_tx_send`, `o_req_done`, `o_err`, `o_busy`, `o_grant_id` = 0.
  - The word in flight is dropped silently.

## Timing
- Accept at edge k → `o_tx_send` high in cycle k+1.
- `i_tx_done` sampled at edge d:
  - Next byte's `o_tx_send` in cycle d+1.
  - Or, after the last byte, `o_req_done` in cycle d+1 and ready possible again in cycle d+2.
- Scheduler overhead is 2 cycles per word plus 1 cycle per byte beyond the UART frame time.
- Timeout: `o_err` pulses TIMEOUT_CYCLES+1 cycles after the SEND cycle.
- All outputs are registered except `o_reqN_ready`.

## Structure
- Shared package `uart_pkg` holds:
  - state encodings (3-bit, IDLE = 0);
  - `UART_REQ_NUM` = 2;
  - `UART_BYTE_IDX_W` = 2;
  - the byte-select function byte(data, idx).
- Counter width is $clog2(TIMEOUT_CYCLES+1), derived locally.
- One sub-module: `uart_tx_rr_arbiter`, a 2-way round-robin arbiter.
  - Inputs: valids, last-grant pointer.
  - Outputs: one-hot grant and grant id.
  - Pointer update is controlled by the scheduler FSM.

## Test plan
- Req0 valid, data 32'hA1B2C3D4, len 3; `i_tx_done` 5 cycles after each send → `o_tx_data` D4, C3, B2, A1 in order; 4 send pulses; `o_req_done` = 2'b01 one cycle after the 4th done.
- Both valid from reset, len 0, data0 8'h11, data1 8'h22 → bytes 11 then 22; next tie goes to req0 again (pointer toggles).
- Req1 held valid continuously with req0 valid once → grants alternate; neither requester is starved.
- TIMEOUT_CYCLES = 8, `i_tx_done` never asserted → `o_err` pulse exactly 9 cycles after `o_tx_send`; no `o_req_done`; `o_busy` low the next cycle.
- Spurious `i_tx_done` in IDLE and coincident with SEND → ignored; byte count unchanged.
- Reset asserted mid-word (after byte 1 of 4) → all outputs 0 immediately; after release, a new req0 len 0 transmits cleanly.
